mask_compactor: RTL
===================

# mask_compactor

Consumes the registered 32-lane prefix-sum vector produced by the mask prefix-adder stage. Uses it to pack the mask-selected words of a 32-word input vector into a dense buffer. Drains that buffer downstream as OUT_LANES words per beat over a valid/ready stream. This removes redundant, mask-cleared lanes before the compute array.

## Interface
- WORD_WIDTH, 8, bit width of one data word.
- OUT_LANES, 4, words per output beat; power of two in 1..32.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream vector valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_data  input  32*WORD_WIDTH  lane i at [i*WORD_WIDTH +: WORD_WIDTH].
- in_mask  input  32  lane i kept when in_mask[i]=1.
- in_psum  input  192  inclusive prefix count for lane i at [i*6 +: 6]; same-cycle aligned with in_data/in_mask (upstream delays data one cycle to match the adder's output register).
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  OUT_LANES*WORD_WIDTH  packed words, lane j at [j*WORD_WIDTH +: WORD_WIDTH].
- out_count  output  clog2(OUT_LANES+1)  number of valid low lanes in this beat.
- out_last  output  1  final beat of the current vector.

## Operation
- States: IDLE and DRAIN.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1, the vector is accepted.
  - Every lane i with in_mask[i]=1 is written to buf[in_psum[i]-1].
  - count is set to in_psum[31] (6 bits, 0..32).
  - beat index k is set to 0. Next state is DRAIN.
- Buffer slots at or above count are written with zero.
- Lanes with in_mask[i]=0 are ignored regardless of their psum.
- A psum inconsistent with the mask gives undefined packed contents. It has no effect on the handshake.
- DRAIN:
  - out_valid=1.
  - Lane j of out_data is buf[k*OUT_LANES+j].
  - out_count = min(OUT_LANES, count - k*OUT_LANES).
  - out_last=1 when (k+1)*OUT_LANES >= count.
- Beats per vector = max(1, ceil(count/OUT_LANES)).
- count=0 produces exactly one beat: out_count=0, out_last=1, out_data all zero.
- Beat handshake (out_valid & out_ready):
  - Not last: k increments.
  - Last: DRAIN exits.
- Back-to-back vectors:
  - In DRAIN, in_ready = out_ready & out_last.
  - A new vector accepted in that cycle reloads buf, count and k=0, and the state stays DRAIN. No idle bubble.
  - If the last beat completes without a new input, the state returns to IDLE.
- When out_ready=0, out_data, out_count and out_last hold stable and out_valid stays 1.
- Lanes j >= out_count in any beat are zero.
- Reset:
  - State forced to IDLE; buf, count and k cleared.
  - out_valid=0, out_data=0, out_count=0, out_last=0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after reset deasserts.
  - Reset in mid-drain discards the remaining beats of the vector.

## Timing
- Input accepted at edge t → first beat out_valid=1 from cycle t+1.
- Prefix-adder mask at edge t-1 → psum at t → compactor output at t+1: two cycles mask-to-first-beat.
- Throughput with out_ready held high: one beat per cycle. A vector needs max(1, ceil(count/OUT_LANES)) cycles.
- in_ready depends combinationally on state, out_ready and out_last only. No path from in_valid to in_ready.
- All outputs except in_ready come from registers.

## Test plan
- Reset, then mask=0xFFFFFFFF, data lane i = i, psum lane i = i+1, out_ready=1 → 8 beats.
  - Beat k carries {4k+3, 4k+2, 4k+1, 4k}, out_count=4.
  - out_last only on beat 7.
  - in_ready=0 on cycles 1-6 of the drain.
- mask=0x80000001, data lane i = 0xA0+i → one beat with lanes {0, 0, 0xBF, 0xA0}, out_count=2, out_last=1.
- mask=0 → single beat, out_count=0, out_last=1, out_data=0, then IDLE.
- Two vectors back-to-back: mask=0x0000000F then 0x000000F0, in_valid held high, out_ready=1.
  - Second vector accepted on the last beat of the first, no idle cycle.
  - Output beats: {3,2,1,0} then {7,6,5,4}.
- Backpressure: mask=0x000000FF, out_ready low for 3 cycles after beat 0 appears.
  - Beat 0 ({3,2,1,0}) holds stable with out_valid=1.
  - Beat 1 ({7,6,5,4}, last) follows after out_ready rises.
- Reset asserted after beat 0 of a full-mask vector → next cycle out_valid=0, all outputs zero, in_ready=1 one cycle after reset falls; no stale beats afterwards.

Source files
------------

// File: rtl/mask_compactor_if.sv
`default_nettype none
// ============================================================================
// Module   : mask_compactor_if
// Purpose  : Bundles the mask_compactor's upstream vector port and its
//            downstream beat stream.
//   in_*   : vector input (valid/ready) carrying 32 data words, lane mask and
//            the 6-bit inclusive prefix-count of the mask for each lane.
//   out_*  : packed beat output (valid/ready) with word count and last flag.
//   master : the side that drives vectors and accepts beats.
//   slave  : the compactor itself.
// Revision : 1.0 - initial release
// ============================================================================
interface mask_compactor_if #(
    parameter int WORD_WIDTH = 8,
    parameter int OUT_LANES  = 4
);
    localparam int c_CNT_W = $clog2(OUT_LANES + 1);

    logic                            in_valid;
    logic                            in_ready;
    logic [32*WORD_WIDTH-1:0]        in_data;
    logic [31:0]                     in_mask;
    logic [191:0]                    in_psum;

    logic                            out_valid;
    logic                            out_ready;
    logic [OUT_LANES*WORD_WIDTH-1:0] out_data;
    logic [c_CNT_W-1:0]              out_count;
    logic                            out_last;

    modport master (
        output in_valid, in_data, in_mask, in_psum, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_last
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_psum, out_ready,
        output in_ready, out_valid, out_data, out_count, out_last
    );
endinterface
`default_nettype wire

// File: rtl/mask_compactor.sv
`default_nettype none
// ============================================================================
// Module   : mask_compactor
// Purpose  : Packs the mask-selected words of a 32-word vector into a dense
//            buffer, using the upstream prefix sums as write addresses, then
//            drains the buffer as OUT_LANES words per beat.
// Ports    : clk   - clock, all state updates on its rising edge
//            reset - synchronous, active-high reset
//            bus   - mask_compactor_if.slave (vector in, beat stream out)
// Revision : 1.0 - initial release
// ============================================================================
module mask_compactor #(
    parameter int WORD_WIDTH = 8,
    parameter int OUT_LANES  = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mask_compactor_if.slave  bus
);
    localparam int c_CNT_W   = $clog2(OUT_LANES + 1);
    localparam int c_LOG2_OL = $clog2(OUT_LANES);
    localparam int c_BEAT_W  = OUT_LANES * WORD_WIDTH;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    // Cleared by reset so in_ready stays low until reset has been released.
    logic                  r_in_en;

    logic [WORD_WIDTH-1:0] r_buf [32];
    logic [WORD_WIDTH-1:0] w_buf_load [32];
    logic [5:0]            r_count;
    logic [5:0]            w_load_count;
    logic [5:0]            r_k;
    logic [5:0]            w_k_next;
    logic [7:0]            w_base_next;

    logic                  r_out_valid;
    logic [c_BEAT_W-1:0]   r_out_data;
    logic [c_CNT_W-1:0]    r_out_count;
    logic                  r_out_last;

    logic [c_BEAT_W-1:0]   w_first_data;
    logic [c_BEAT_W-1:0]   w_next_data;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_fire;

    // Words carried by the beat starting at buffer slot 'base'.
    function automatic logic [c_CNT_W-1:0] beat_count(input logic [5:0] count,
                                                      input logic [7:0] base);
        logic [7:0] rem;
        rem = (8'(count) > base) ? (8'(count) - base) : 8'd0;
        if (rem >= 8'(OUT_LANES))
            return c_CNT_W'(OUT_LANES);
        return c_CNT_W'(rem);
    endfunction

    // A beat is last once it reaches or passes the end of the packed data.
    function automatic logic beat_last(input logic [5:0] count,
                                       input logic [7:0] base);
        return (base + 8'(OUT_LANES)) >= 8'(count);
    endfunction

    // Scatter: slot s receives the kept lane whose inclusive prefix count is
    // s+1. With a consistent psum at most one lane matches, so an OR merge is
    // a valid mux. Slots at or above the count are forced to zero so unused
    // output lanes are always zero.
    always_comb begin
        w_load_count = bus.in_psum[31*6 +: 6];
        for (int s = 0; s < 32; s++) begin
            w_buf_load[s] = '0;
            for (int i = 0; i < 32; i++) begin
                if (bus.in_mask[i] && (bus.in_psum[i*6 +: 6] == 6'(s + 1)))
                    w_buf_load[s] = w_buf_load[s] | bus.in_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
            if (6'(s) >= w_load_count)
                w_buf_load[s] = '0;
        end
    end

    assign w_k_next    = r_k + 6'd1;
    assign w_base_next = 8'(w_k_next) << c_LOG2_OL;

    // First beat comes straight from the scatter result; later beats from
    // the stored buffer.
    always_comb begin
        w_first_data = '0;
        w_next_data  = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            w_first_data[j*WORD_WIDTH +: WORD_WIDTH] = w_buf_load[j];
            if ((w_base_next + 8'(j)) < 8'd32)
                w_next_data[j*WORD_WIDTH +: WORD_WIDTH] = r_buf[5'(w_base_next + 8'(j))];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // in_ready looks only at state, out_ready and the registered last flag.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = r_in_en;
                if (bus.in_valid && r_in_en)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_in_ready = bus.out_ready & r_out_last;
                if (bus.out_ready && r_out_last && !bus.in_valid)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_fire   = r_out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_en     <= 1'b0;
            r_count     <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
            for (int s = 0; s < 32; s++)
                r_buf[s] <= '0;
        end else begin
            r_in_en <= 1'b1;
            if (w_accept) begin
                // A new vector may land on the last beat of the previous one.
                for (int s = 0; s < 32; s++)
                    r_buf[s] <= w_buf_load[s];
                r_count     <= w_load_count;
                r_k         <= '0;
                r_out_valid <= 1'b1;
                r_out_data  <= w_first_data;
                r_out_count <= beat_count(w_load_count, 8'd0);
                r_out_last  <= beat_last(w_load_count, 8'd0);
            end else if (w_fire) begin
                if (r_out_last) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_out_count <= '0;
                    r_out_last  <= 1'b0;
                end else begin
                    r_k         <= w_k_next;
                    r_out_data  <= w_next_data;
                    r_out_count <= beat_count(r_count, w_base_next);
                    r_out_last  <= beat_last(r_count, w_base_next);
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire
